// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Define UART_TX_ARB_LOCK_TIMEOUT_EN to add the idle-lock timeout and the lock_abort output.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int IDX_W        = 2,
    parameter int LOCK_TIMEOUT = 250000
) (
    input  logic                 clk48,
    input  logic                 boot_reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    output logic                 lock_abort,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACCEPT, DRAIN} state_t;

    state_t           state;
    state_t           next_state;
    logic             lock;
    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    logic [IDX_W-1:0] winner;
    logic             transfer;
    logic             timeout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ || LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // While locked, rr_ptr doubles as the owner index; otherwise search starts just past it.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        if (lock) begin
            found = req_valid[rr_ptr];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && req_valid[wrap_idx(rr_ptr, k)]) begin
                    found  = 1'b1;
                    winner = wrap_idx(rr_ptr, k);
                end
            end
        end
    end

    assign transfer = (state == IDLE) && found;

    always_ff @(posedge clk48 or posedge boot_reset) begin
        if (boot_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found)     next_state = ISSUE;
            ISSUE:   if (tx_ready)  next_state = ACCEPT;
            ACCEPT:  if (!tx_ready) next_state = DRAIN;
            DRAIN:   if (tx_ready)  next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready = NUM_REQ'(1) << winner;
        end
        tx_valid = (state == ACCEPT);
        busy     = (state != IDLE) || lock;
    end

    always_ff @(posedge clk48 or posedge boot_reset) begin
        if (boot_reset) begin
            tx_data <= '0;
            grant   <= '0;
            lock    <= 1'b0;
            rr_ptr  <= IDX_W'(NUM_REQ - 1);
        end else if (transfer) begin
            tx_data <= req_data[{winner, 3'b000} +: 8];
            grant   <= NUM_REQ'(1) << winner;
            lock    <= ~req_last[winner];
            rr_ptr  <= winner;
        end else if (timeout_hit) begin
            lock  <= 1'b0;
            grant <= '0;
        end else if (state == DRAIN && tx_ready && !lock) begin
            grant <= '0;
        end
    end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             counting;

    // Only a locked owner that has gone silent in IDLE burns down the timeout.
    assign counting    = lock && (state == IDLE) && !req_valid[rr_ptr];
    assign timeout_hit = counting && (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk48 or posedge boot_reset) begin
        if (boot_reset) begin
            idle_cnt   <= '0;
            lock_abort <= 1'b0;
        end else begin
            lock_abort <= timeout_hit;
            if (transfer || timeout_hit) begin
                idle_cnt <= '0;
            end else if (counting) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    a_ready_onehot: assert property (@(posedge clk48) disable iff (boot_reset) $onehot0(req_ready));
    a_grant_onehot: assert property (@(posedge clk48) disable iff (boot_reset) $onehot0(grant));
    a_lock_has_owner: assert property (@(posedge clk48) disable iff (boot_reset) lock |-> (grant != '0));

endmodule
